// File: rtl/game_pkg.sv
// Shared types and default constants for the door-guessing game.
//   round_state_t : round sequencer state (IDLE=0, PLAY=1, REVEAL=2, OVER=3)
//   *_DEFAULT     : default timing and lives constants for the top level
//   max_u         : helper for sizing counters from two limits
package game_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPlay   = 2'd1,
    StReveal = 2'd2,
    StOver   = 2'd3
  } round_state_t;

  localparam int unsigned CLK_HZ_DEFAULT     = 25_000_000;
  localparam int unsigned ROUND_SEC_DEFAULT  = 10;
  localparam int unsigned PAUSE_SEC_DEFAULT  = 1;
  localparam int unsigned LIVES_INIT_DEFAULT = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and pulses tick_o on the
// wrap cycle. Shared with the seven-segment timer path.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   enable_i : count when high, freeze when low
//   clear_i  : return count to zero on the next edge (wins over enable)
//   tick_o   : high for the cycle the counter sits at CLK_HZ-1 while enabled
module sec_prescaler
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: timed PLAY phase, timed REVEAL pause, per-player scoring
// with lives, game-over detection and winner report. All outputs are registered.
//   clk_i / reset_i          : clock, synchronous active-high reset
//   hold_i                   : (ROUND_CTRL_HOLD_EN only) freezes timing in PLAY/REVEAL
//   start_i                  : starts a game from IDLE or OVER
//   player_pos_i             : NUM_PLAYERS x DOOR_W chosen doors, player p at [p*DOOR_W +: DOOR_W]
//   correct_door_i           : NUM_PLAYERS x DOOR_W correct doors, same packing
//   state_o                  : IDLE=0, PLAY=1, REVEAL=2, OVER=3
//   seconds_o / sec_tick_o   : elapsed seconds in phase / one-cycle pulse per second
//   reveal_o                 : high while in REVEAL
//   lives_o                  : NUM_PLAYERS x LIFE_W remaining lives, same packing
//   round_num_o              : completed rounds, saturating at 255
//   winner_o / winner_valid_o: lowest surviving index / exactly one survivor in OVER
// Optional feature macro: ROUND_CTRL_HOLD_EN adds the hold_i port.
module round_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_DOORS   = 4,
  parameter int unsigned LIVES_INIT  = LIVES_INIT_DEFAULT,
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned ROUND_SEC   = ROUND_SEC_DEFAULT,
  parameter int unsigned PAUSE_SEC   = PAUSE_SEC_DEFAULT,
  localparam int unsigned DOOR_W     = (NUM_DOORS > 1) ? $clog2(NUM_DOORS) : 1,
  localparam int unsigned LIFE_W     = (LIVES_INIT > 0) ? $clog2(LIVES_INIT + 1) : 1,
  localparam int unsigned SEC_W      = $clog2(ROUND_SEC + 1),
  localparam int unsigned WIN_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
`ifdef ROUND_CTRL_HOLD_EN
  input  logic                          hold_i,
`endif
  input  logic                          start_i,
  input  logic [NUM_PLAYERS*DOOR_W-1:0] player_pos_i,
  input  logic [NUM_PLAYERS*DOOR_W-1:0] correct_door_i,
  output logic [1:0]                    state_o,
  output logic [SEC_W-1:0]              seconds_o,
  output logic                          sec_tick_o,
  output logic                          reveal_o,
  output logic [NUM_PLAYERS*LIFE_W-1:0] lives_o,
  output logic [7:0]                    round_num_o,
  output logic [WIN_W-1:0]              winner_o,
  output logic                          winner_valid_o
);

  // Internal seconds counter must hold whichever phase limit is larger.
  localparam int unsigned SecCntW = $clog2(max_u(ROUND_SEC, PAUSE_SEC) + 1);
  localparam int unsigned AliveW  = $clog2(NUM_PLAYERS + 1);

  round_state_t        state_q, state_d;
  logic [SecCntW-1:0]  seconds_q, seconds_d;
  logic                sec_tick_q;
  logic [7:0]          round_q, round_d;
  logic [WIN_W-1:0]    winner_q, winner_d;
  logic                winner_valid_q, winner_valid_d;
  logic [LIFE_W-1:0]   lives_q      [NUM_PLAYERS];
  logic [LIFE_W-1:0]   lives_d      [NUM_PLAYERS];
  logic [LIFE_W-1:0]   lives_scored [NUM_PLAYERS];

  logic                hold;
  logic                running;
  logic                tick;
  logic                phase_clear;
  logic [AliveW-1:0]   alive;
  logic [WIN_W-1:0]    first_alive;
  logic                found;
  logic                game_done;

`ifdef ROUND_CTRL_HOLD_EN
  assign hold = hold_i;
`else
  assign hold = 1'b0;
`endif

  assign running     = ((state_q == StPlay) || (state_q == StReveal)) && !hold;
  assign phase_clear = (state_d != state_q);

  sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_prescaler (
    .clk_i    (clk_i),
    .rst_i    (reset_i),
    .enable_i (running),
    .clear_i  (phase_clear),
    .tick_o   (tick)
  );

  // Per-player scoring: eliminated players keep 0 and their inputs are ignored.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    logic [DOOR_W-1:0] pos;
    logic [DOOR_W-1:0] door;
    assign pos  = player_pos_i[p*DOOR_W +: DOOR_W];
    assign door = correct_door_i[p*DOOR_W +: DOOR_W];
    assign lives_scored[p] = ((lives_q[p] != '0) && (pos != door)) ?
                             lives_q[p] - LIFE_W'(1) : lives_q[p];
    assign lives_o[p*LIFE_W +: LIFE_W] = lives_q[p];
  end

  always_comb begin
    alive       = '0;
    first_alive = '0;
    found       = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (lives_q[p] != '0) begin
        alive = alive + AliveW'(1);
        if (!found) begin
          first_alive = WIN_W'(p);
          found       = 1'b1;
        end
      end
    end
  end

  // A single-player game continues until that player is out.
  assign game_done = (NUM_PLAYERS == 1) ? (alive == '0) : (alive <= AliveW'(1));

  always_comb begin
    state_d        = state_q;
    seconds_d      = seconds_q;
    round_d        = round_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    lives_d        = lives_q;

    if (tick) begin
      seconds_d = seconds_q + SecCntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
          lives_d[p] = LIFE_W'(LIVES_INIT);
        end
        round_d = '0;
        if (start_i) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tick && (seconds_q + SecCntW'(1) == SecCntW'(ROUND_SEC))) begin
          state_d = StReveal;
          lives_d = lives_scored;
          if (round_q != 8'hFF) begin
            round_d = round_q + 8'd1;
          end
        end
      end
      StReveal: begin
        if (tick && (seconds_q + SecCntW'(1) == SecCntW'(PAUSE_SEC))) begin
          if (game_done) begin
            state_d        = StOver;
            winner_d       = first_alive;
            winner_valid_d = (alive == AliveW'(1));
          end else begin
            state_d = StPlay;
          end
        end
      end
      StOver: begin
        if (start_i) begin
          state_d        = StPlay;
          round_d        = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            lives_d[p] = LIFE_W'(LIVES_INIT);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      seconds_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      seconds_q      <= '0;
      sec_tick_q     <= 1'b0;
      round_q        <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        lives_q[p] <= LIFE_W'(LIVES_INIT);
      end
    end else begin
      state_q        <= state_d;
      seconds_q      <= seconds_d;
      sec_tick_q     <= tick;
      round_q        <= round_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      lives_q        <= lives_d;
    end
  end

  assign state_o        = state_q;
  assign seconds_o      = seconds_q[SEC_W-1:0];
  assign sec_tick_o     = sec_tick_q;
  assign reveal_o       = (state_q == StReveal);
  assign round_num_o    = round_q;
  assign winner_o       = winner_q;
  assign winner_valid_o = winner_valid_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller (CLK_HZ=4, ROUND_SEC=3, PAUSE_SEC=1,
// NUM_PLAYERS=2, LIVES_INIT=2). A phase-timing reference model predicts every
// output each cycle; directed steps add explicit checks on the key scenarios.
module tb_round_controller;

  localparam int unsigned NP = 2;
  localparam int unsigned ND = 4;
  localparam int unsigned LI = 2;
  localparam int unsigned CH = 4;
  localparam int unsigned RS = 3;
  localparam int unsigned PS = 1;
  localparam int unsigned DW = 2;
  localparam int unsigned LW = 2;
  localparam int unsigned SW = 2;
  localparam int unsigned WW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               start;
  logic [NP*DW-1:0]   player_pos;
  logic [NP*DW-1:0]   correct_door;
  logic [1:0]         state_o;
  logic [SW-1:0]      seconds_o;
  logic               sec_tick_o;
  logic               reveal_o;
  logic [NP*LW-1:0]   lives_o;
  logic [7:0]         round_num_o;
  logic [WW-1:0]      winner_o;
  logic               winner_valid_o;
  bit                 hold_v;
`ifdef ROUND_CTRL_HOLD_EN
  logic               hold;
  assign hold = hold_v;
`endif

  round_controller #(
    .NUM_PLAYERS (NP),
    .NUM_DOORS   (ND),
    .LIVES_INIT  (LI),
    .CLK_HZ      (CH),
    .ROUND_SEC   (RS),
    .PAUSE_SEC   (PS)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
`ifdef ROUND_CTRL_HOLD_EN
    .hold_i         (hold),
`endif
    .start_i        (start),
    .player_pos_i   (player_pos),
    .correct_door_i (correct_door),
    .state_o        (state_o),
    .seconds_o      (seconds_o),
    .sec_tick_o     (sec_tick_o),
    .reveal_o       (reveal_o),
    .lives_o        (lives_o),
    .round_num_o    (round_num_o),
    .winner_o       (winner_o),
    .winner_valid_o (winner_valid_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state 0..3, cycles spent in current phase, pending tick.
  int m_state, m_k, m_round, m_winner, m_wv;
  bit m_tick;
  int m_lives [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int field(input logic [NP*DW-1:0] v, input int p);
    return int'(v[p*DW +: DW]);
  endfunction

  task automatic reload_model();
    foreach (m_lives[p]) m_lives[p] = LI;
    m_round = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    int  ns, nk, alive, first;
    bit  run;
    if (reset) begin
      m_state = 0; m_k = 0; m_tick = 0; m_winner = 0; m_wv = 0;
      reload_model();
      return;
    end
    run = (m_state == 1 || m_state == 2) && !hold_v;
    ns  = m_state;
    nk  = run ? m_k + 1 : m_k;
    m_tick = run && ((m_k + 1) % CH == 0);
    case (m_state)
      0: if (start) begin ns = 1; reload_model(); end
      1: if (run && m_k + 1 == RS * CH) begin
           ns = 2;
           for (int p = 0; p < NP; p++)
             if (m_lives[p] > 0 && field(player_pos, p) != field(correct_door, p))
               m_lives[p]--;
           if (m_round < 255) m_round++;
         end
      2: if (run && m_k + 1 == PS * CH) begin
           alive = 0; first = -1;
           for (int p = 0; p < NP; p++)
             if (m_lives[p] > 0) begin
               alive++;
               if (first < 0) first = p;
             end
           if (alive <= 1) begin
             ns = 3;
             m_wv = (alive == 1);
             m_winner = (first < 0) ? 0 : first;
           end else begin
             ns = 1;
           end
         end
      3: if (start) begin ns = 1; reload_model(); m_winner = 0; m_wv = 0; end
      default: ns = 0;
    endcase
    if (ns != m_state) nk = 0;
    m_state = ns;
    m_k     = nk;
  endtask

  task automatic check_model();
    logic [31:0] exp_l;
    exp_l = '0;
    for (int p = 0; p < NP; p++) exp_l |= 32'(m_lives[p]) << (p * LW);
    chk("state", 32'(state_o), 32'(m_state));
    chk("seconds", 32'(seconds_o), (m_state == 1 || m_state == 2) ? 32'(m_k / CH) : 32'd0);
    chk("sec_tick", 32'(sec_tick_o), 32'(m_tick));
    chk("reveal", 32'(reveal_o), 32'(m_state == 2));
    chk("lives", 32'(lives_o), exp_l);
    chk("round_num", 32'(round_num_o), 32'(m_round));
    chk("winner", 32'(winner_o), 32'(m_winner));
    chk("winner_valid", 32'(winner_valid_o), 32'(m_wv));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_player(input int p, input bit right);
    int d, q;
    d = $urandom_range(0, ND - 1);
    q = right ? d : (d + 1 + $urandom_range(0, ND - 2)) % ND;
    correct_door[p*DW +: DW] = DW'(d);
    player_pos[p*DW +: DW]   = DW'(q);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_seconds"}, 32'(seconds_o), 32'd0);
    chk({tag, "_tick"}, 32'(sec_tick_o), 32'd0);
    chk({tag, "_reveal"}, 32'(reveal_o), 32'd0);
    chk({tag, "_lives"}, 32'(lives_o), 32'h0000_000A);
    chk({tag, "_round"}, 32'(round_num_o), 32'd0);
    chk({tag, "_winner"}, 32'(winner_o), 32'd0);
    chk({tag, "_wvalid"}, 32'(winner_valid_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; hold_v = 1'b0;
    player_pos = '0; correct_door = '0;
    m_state = 0; m_k = 0; m_tick = 0; m_winner = 0; m_wv = 0;
    reload_model();
    @(posedge clk); #1;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    check_reset_values("rst");

    // Game 1: P0 correct, P1 wrong for two rounds -> P0 wins.
    start = 1'b1; cycle(); start = 1'b0;
    chk("start_to_play", 32'(state_o), 32'd1);
    set_player(0, 1'b1); set_player(1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i == 3 || i == 7) chk("tick_period", 32'(sec_tick_o), 32'd1);
      if (i == 10) chk("play_len", 32'(state_o), 32'd1);
    end
    chk("r1_reveal", 32'(state_o), 32'd2);
    chk("r1_lives", 32'(lives_o), 32'h6);
    chk("r1_round", 32'(round_num_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) chk("r1_reveal_hi", 32'(reveal_o), 32'd1);
      cycle();
    end
    chk("r1_back_play", 32'(state_o), 32'd1);
    set_player(0, 1'b1); set_player(1, 1'b0);
    repeat (16) cycle();
    chk("g1_over", 32'(state_o), 32'd3);
    chk("g1_lives", 32'(lives_o), 32'h2);
    chk("g1_winner", 32'(winner_o), 32'd0);
    chk("g1_wvalid", 32'(winner_valid_o), 32'd1);
    chk("g1_round", 32'(round_num_o), 32'd2);
    repeat (5) begin set_player(0, 1'b0); set_player(1, 1'b0); cycle(); end
    chk("over_holds", 32'(state_o), 32'd3);

    // Game 2: both wrong twice -> draw.
    start = 1'b1; cycle(); start = 1'b0;
    chk("g2_restart_lives", 32'(lives_o), 32'hA);
    chk("g2_restart_round", 32'(round_num_o), 32'd0);
    set_player(0, 1'b0); set_player(1, 1'b0);
    repeat (16) cycle();
    chk("g2_mid_lives", 32'(lives_o), 32'h5);
    chk("g2_mid_state", 32'(state_o), 32'd1);
    set_player(0, 1'b0); set_player(1, 1'b0);
    repeat (16) cycle();
    chk("g2_over", 32'(state_o), 32'd3);
    chk("g2_lives", 32'(lives_o), 32'h0);
    chk("g2_wvalid", 32'(winner_valid_o), 32'd0);
    chk("g2_winner", 32'(winner_o), 32'd0);

    // Start ignored in PLAY; reset on the would-be round-end edge wins.
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();
    chk("mid_seconds", 32'(seconds_o), 32'd2);
    start = 1'b1;
    repeat (3) cycle();
    chk("start_ignored", 32'(state_o), 32'd1);
    reset = 1'b1; cycle();
    reset = 1'b0; start = 1'b0;
    check_reset_values("midrst");

`ifdef ROUND_CTRL_HOLD_EN
    begin
      int n;
      start = 1'b1; cycle(); start = 1'b0;
      n = 0;
      repeat (5) begin cycle(); n++; end
      hold_v = 1'b1;
      repeat (10) begin cycle(); n++; chk("hold_freeze", 32'(seconds_o), 32'd1); end
      hold_v = 1'b0;
      while (state_o != 2'd2 && n < 40) begin cycle(); n++; end
      chk("hold_len", 32'(n), 32'd22);
      reset = 1'b1; cycle(); reset = 1'b0;
    end
`endif

    // Randomised games against the model.
    for (int g = 0; g < 6; g++) begin
      start = 1'b1; cycle(); start = 1'b0;
      for (int c = 0; c < 400 && m_state != 3; c++) begin
        for (int p = 0; p < NP; p++) set_player(p, 1'($urandom_range(0, 1)));
        start = ($urandom_range(0, 7) == 0);
        reset = ($urandom_range(0, 299) == 0);
`ifdef ROUND_CTRL_HOLD_EN
        hold_v = ($urandom_range(0, 5) == 0);
`endif
        cycle();
        if (m_state == 0) begin reset = 1'b0; start = 1'b1; end
      end
      reset = 1'b0; start = 1'b0; hold_v = 1'b0;
      repeat (3) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
